// File: rtl/step_motor_sequencer.sv
// Command-driven AX/AY/BX/BY phase sequencer for one bipolar stepper channel.
// Optional half-step support is compiled in with `define STEP_MOTOR_HALF_STEP_EN.
module step_motor_sequencer #(
  parameter int STEP_W   = 16,
  parameter int PERIOD_W = 16,
  parameter int POS_W    = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_dir,
  input  logic                cmd_half,
  input  logic [STEP_W-1:0]   cmd_steps,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic                abort,
  input  logic                hold,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [POS_W-1:0]    position,
  output logic                AX,
  output logic                AY,
  output logic                BX,
  output logic                BY
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_idx, w_idx_nxt;
  logic [POS_W-1:0]    r_pos, w_pos_nxt;
  logic [STEP_W-1:0]   r_rem, w_rem_nxt;
  logic [PERIOD_W-1:0] r_timer, w_timer_nxt;
  logic [PERIOD_W-1:0] r_period, w_period_nxt;
  logic                r_dir, w_dir_nxt;
  logic                r_half, w_half_nxt;
  logic                r_abt, w_abt_nxt;
  logic [3:0]          r_coils, w_coils_nxt;
  logic                w_half_cmd;
  logic [2:0]          w_stride;
  logic [PERIOD_W-1:0] w_cmd_period;

`ifdef STEP_MOTOR_HALF_STEP_EN
  assign w_half_cmd = cmd_half;
`else
  logic w_unused_half;
  assign w_unused_half = cmd_half;
  assign w_half_cmd    = 1'b0;
`endif

  function automatic logic [3:0] phase_coils(input logic [2:0] i);
    case (i)
      3'd0:    phase_coils = 4'b1000;
      3'd1:    phase_coils = 4'b1010;
      3'd2:    phase_coils = 4'b0010;
      3'd3:    phase_coils = 4'b0110;
      3'd4:    phase_coils = 4'b0100;
      3'd5:    phase_coils = 4'b0101;
      3'd6:    phase_coils = 4'b0001;
      default: phase_coils = 4'b1001;
    endcase
  endfunction

  // Full-step always lands on an odd (two-coil) index: odd moves by 2, even by 1.
  assign w_stride     = (r_half || !r_idx[0]) ? 3'd1 : 3'd2;
  assign w_cmd_period = (cmd_period == '0) ? PERIOD_W'(1) : cmd_period;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_idx    <= 3'd1;
      r_pos    <= '0;
      r_rem    <= '0;
      r_timer  <= '0;
      r_period <= '0;
      r_dir    <= 1'b0;
      r_half   <= 1'b0;
      r_abt    <= 1'b0;
      r_coils  <= 4'b0000;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_pos    <= w_pos_nxt;
      r_rem    <= w_rem_nxt;
      r_timer  <= w_timer_nxt;
      r_period <= w_period_nxt;
      r_dir    <= w_dir_nxt;
      r_half   <= w_half_nxt;
      r_abt    <= w_abt_nxt;
      r_coils  <= w_coils_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_pos_nxt    = r_pos;
    w_rem_nxt    = r_rem;
    w_timer_nxt  = r_timer;
    w_period_nxt = r_period;
    w_dir_nxt    = r_dir;
    w_half_nxt   = r_half;
    w_abt_nxt    = r_abt;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_dir_nxt    = cmd_dir;
          w_half_nxt   = w_half_cmd;
          w_rem_nxt    = cmd_steps;
          w_timer_nxt  = w_cmd_period;
          w_period_nxt = w_cmd_period;
          w_abt_nxt    = 1'b0;
          w_state_nxt  = (cmd_steps == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // Abort wins over a step falling due in the same cycle.
        if (abort) begin
          w_abt_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_rem == '0) begin
          w_state_nxt = S_DONE;
        end else if (r_timer == PERIOD_W'(1)) begin
          w_idx_nxt   = r_dir ? r_idx + w_stride : r_idx - w_stride;
          w_pos_nxt   = r_dir ? r_pos + POS_W'(1) : r_pos - POS_W'(1);
          w_rem_nxt   = r_rem - STEP_W'(1);
          w_timer_nxt = r_period;
        end else begin
          w_timer_nxt = r_timer - PERIOD_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Coils are registered from next-state values so a step shows on the same edge it is taken.
    w_coils_nxt = (w_state_nxt == S_RUN || hold) ? phase_coils(w_idx_nxt) : 4'b0000;
  end

  assign cmd_ready        = (r_state == S_IDLE);
  assign busy             = (r_state == S_RUN);
  assign done             = (r_state == S_DONE);
  assign aborted          = done & r_abt;
  assign position         = r_pos;
  assign {AX, AY, BX, BY} = r_coils;

endmodule

// File: tb/tb_step_motor_sequencer.sv
// Self-checking bench: directed and random moves against a timeline model of the sequencer.
module tb_step_motor_sequencer;
  logic        clk = 1'b0, reset_n = 1'b0, cmd_valid = 1'b0, cmd_dir = 1'b0, cmd_half = 1'b0;
  logic        abort = 1'b0, hold = 1'b0;
  logic [15:0] cmd_steps = '0, cmd_period = '0;
  logic        cmd_ready, busy, done, aborted, AX, AY, BX, BY;
  logic [15:0] position;

  int tests = 0;
  int fails = 0;
  int m_idx = 1;
  int m_pos = 0;
  logic [3:0] tbl [8];

  step_motor_sequencer #(.STEP_W(16), .PERIOD_W(16), .POS_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_half(cmd_half), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
    .abort(abort), .hold(hold), .busy(busy), .done(done), .aborted(aborted),
    .position(position), .AX(AX), .AY(AY), .BX(BX), .BY(BY)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Next phase index: half-step moves by one; full-step goes to the next odd index in direction.
  function automatic int nxt_idx(input int i, input bit dir, input bit half);
    if (half) return dir ? (i + 1) % 8 : (i + 7) % 8;
    return dir ? ((i + 1) | 1) % 8 : ((i + 6) | 1) % 8;
  endfunction

  task automatic do_reset(input bit hld);
    @(negedge clk);
    reset_n = 1'b0; hold = hld; cmd_valid = 1'b0; abort = 1'b0;
    #2;
    chk("reset_flags", {cmd_ready, busy, done, aborted, AX, AY, BX, BY}, 32'h80);
    chk("reset_pos", position, 32'h0);
    @(negedge clk);
    reset_n = 1'b1; m_idx = 1; m_pos = 0;
    @(negedge clk);
    chk("reset_hold_coils", {AX, AY, BX, BY}, hld ? 32'hA : 32'h0);
  endtask

  // n steps, requested period per, hold level hld, abort sampled on edge ab after accept (0 = none),
  // junk = present rejected commands while the move is busy.
  task automatic run_move(input bit dir, input bit half, input int n, input int per,
                          input bit hld, input int ab, input bit junk);
    int P, E, s, idx;
    bit heff, abd;
    logic [7:0] e;
    P = (per == 0) ? 1 : per;
`ifdef STEP_MOTOR_HALF_STEP_EN
    heff = half;
`else
    heff = 1'b0;
`endif
    if (n == 0)      begin E = 0;         abd = 1'b0; end
    else if (ab > 0) begin E = ab;        abd = 1'b1; end
    else             begin E = n * P + 1; abd = 1'b0; end
    @(negedge clk);
    chk("ready_before_cmd", cmd_ready, 32'h1);
    cmd_valid = 1'b1; cmd_dir = dir; cmd_half = half;
    cmd_steps = 16'(n); cmd_period = 16'(per); hold = hld;
    abort = 1'($urandom % 2);
    for (int c = 0; c <= E + 1; c++) begin
      @(negedge clk);
      s = (abd && c >= ab) ? (ab - 1) / P : c / P;
      if (s > n) s = n;
      idx = m_idx;
      for (int k = 0; k < s; k++) idx = nxt_idx(idx, dir, heff);
      e[7] = (c > E);
      e[6] = (c < E);
      e[5] = (c == E);
      e[4] = (c == E) && abd;
      e[3:0] = ((c < E) || hld) ? tbl[idx] : 4'b0000;
      chk($sformatf("flags_c%0d", c), {cmd_ready, busy, done, aborted, AX, AY, BX, BY}, {24'h0, e});
      chk($sformatf("pos_c%0d", c), position, {16'h0, 16'(m_pos + (dir ? s : -s))});
      abort = abd ? (c + 1 == ab) : (c == E);
      cmd_valid = junk && (c + 1 <= E);
      if (cmd_valid) begin
        cmd_dir = 1'($urandom); cmd_half = 1'($urandom);
        cmd_steps = 16'($urandom_range(0, 9)); cmd_period = 16'($urandom_range(0, 5));
      end
    end
    m_idx = idx;
    m_pos = m_pos + (dir ? s : -s);
    abort = 1'b0; cmd_valid = 1'b0;
  endtask

  initial begin
    int n, per, ab;
    tbl[0] = 4'b1000; tbl[1] = 4'b1010; tbl[2] = 4'b0010; tbl[3] = 4'b0110;
    tbl[4] = 4'b0100; tbl[5] = 4'b0101; tbl[6] = 4'b0001; tbl[7] = 4'b1001;

    do_reset(1'b1);
    // Forward full-step, period 3: steps at +3,6,9,12, done at +13.
    run_move(1'b1, 1'b0, 4, 3, 1'b1, 0, 1'b0);
    chk("fwd_pos", position, 32'h4);
    chk("fwd_coils", {AX, AY, BX, BY}, 32'hA);

    do_reset(1'b0);
    run_move(1'b0, 1'b0, 2, 1, 1'b0, 0, 1'b0);
    chk("rev_pos", position, 32'hFFFE);

    run_move(1'b1, 1'b0, 0, 5, 1'b1, 0, 1'b0);
    run_move(1'b1, 1'b0, 2, 0, 1'b0, 0, 1'b1);

    do_reset(1'b0);
    run_move(1'b1, 1'b0, 100, 10, 1'b0, 50, 1'b1);
    chk("abort_pos", position, 32'h4);

    do_reset(1'b1);
    run_move(1'b1, 1'b1, 3, 2, 1'b1, 0, 1'b0);
    chk("half_pos", position, 32'h3);
`ifdef STEP_MOTOR_HALF_STEP_EN
    chk("half_coils", {AX, AY, BX, BY}, 32'h4);
`else
    chk("half_coils", {AX, AY, BX, BY}, 32'h9);
`endif

    for (int t = 0; t < 40; t++) begin
      n   = $urandom_range(0, 6);
      per = $urandom_range(0, 3);
      ab  = 0;
      if (n > 0 && ($urandom % 3) == 0) ab = $urandom_range(1, n * ((per == 0) ? 1 : per));
      run_move(1'($urandom), 1'($urandom), n, per, 1'($urandom), ab, 1'($urandom));
    end

    // Reset in the middle of a move drops it and restores reset values.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_half = 1'b0; cmd_steps = 16'd10; cmd_period = 16'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("busy_mid_move", busy, 32'h1);
    do_reset(1'b1);
    run_move(1'b0, 1'b0, 3, 1, 1'b0, 0, 1'b0);
    chk("post_reset_pos", position, 32'hFFFD);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
